smoldvi_pattern_gen: RTL
========================

// Module: smoldvi_pattern_gen
// PURPOSE
//  Parametrised test-pattern source for the smoldvi encoder, in the clk_pix domain.
//  Walks x/y/frame counters under the encoder's rgb_rdy pull handshake.
//  Emits one of four selectable patterns: gradient, colour bars, checkerboard, solid.
//  Replaces ad-hoc top-level counters; resolution and pixel repeat are parameters.
// PARAMETERS
//  H_ACTIVE    640  active pixels per line (multiple of 8*X_STEP)
//  V_ACTIVE    480  active lines per frame
//  X_STEP      2    x increment per accepted pixel (2 = pixel doubling), power of 2
//  FRAME_W     8    frame counter width
//  CHECK_LOG2  5    checkerboard square size = 2**CHECK_LOG2 pixels
// PORTS
//  clk_pix     in   1        pixel clock
//  rst_pix     in   1        synchronous reset, active high
//  mode        in   2        0 gradient, 1 bars, 2 checker, 3 solid
//  solid_rgb   in   24       {r,g,b} used in mode 3
//  freeze      in   1        hold frame counter (patterns stop animating)
//  rgb_rdy     in   1        encoder accepted current r/g/b this cycle
//  r, g, b     out  8 each   current pixel colour (registered)
//  x           out  clog2(H_ACTIVE)  current x coordinate
//  y           out  clog2(V_ACTIVE)  current y coordinate
//  frame       out  FRAME_W  frame counter
//  sof         out  1        high while current pixel is (0,0)
//  eol         out  1        high while current pixel is last of line
// BEHAVIOUR
//  - Source always valid; r/g/b/x/y describe the pixel the encoder consumes next.
//  - rgb_rdy=1 at edge n: at n+1 all outputs show the following pixel. rgb_rdy=0: outputs hold.
//  - Advance: x += X_STEP. If x == H_ACTIVE-X_STEP, x -> 0 and y += 1.
//    If additionally y == V_ACTIVE-1, y -> 0 and frame += 1 (unless freeze).
//  - frame wraps modulo 2**FRAME_W; freeze sampled at the wrap edge only.
//  - mode and solid_rgb are latched into mode_q/solid_q on reset and on each frame wrap.
//    Mid-frame changes take effect at the next (0,0). Reset latches live inputs.
//  - Colour is computed from next-state coords and mode_q and registered with them.
//    Zero combinational path from inputs to r/g/b.
//  - Gradient: r = x+frame, g = y+2*frame, b = frame. Each term zero-extended; sum truncated to 8 bits.
//  - Bars: bar = x / (H_ACTIVE/8), 0..7.
//    Colours: white, yellow, cyan, green, magenta, red, blue, black.
//    Components are 8'hFF / 8'h00 only.
//  - Checker: (x[CHECK_LOG2] ^ y[CHECK_LOG2] ^ frame[0]) ? FFFFFF : 000000.
//  - Solid: {r,g,b} = solid_q.
//  - sof = (x==0 && y==0). eol = (x == H_ACTIVE-X_STEP). Both registered with the coords.
//  - Reset (any cycle, incl. mid-line): x=0, y=0, frame=0, sof=1, eol=0.
//    r/g/b = pattern at (0,0) frame 0 for the latched mode.
//    rgb_rdy is ignored during reset.
//  - Reset takes priority over rgb_rdy.
//  - No illegal state exists; counters never exceed their wrap values.
// TESTING
//  1 Reset, mode=0, rgb_rdy=1 for 320 cycles -> x steps 0,2,..,638 then 0; y=1.
//    eol high only at x=638.
//  2 Hold rgb_rdy=0 for 10 cycles mid-line -> all outputs frozen.
//    Next rgb_rdy advances exactly one pixel.
//  3 Run 320*480 accepts -> frame 0->1 and sof re-asserts.
//    Gradient at (0,0): r=1, g=2, b=1.
//  4 Set mode=1 mid-frame -> pattern unchanged until (0,0).
//    Then x=0 gives FFFFFF; x=80 gives FFFF00; x=560 gives 000000.
//  5 mode=3, solid_rgb=123456, freeze=1 over 3 frames -> r=12, g=34, b=56; frame constant.
//  6 Assert rst_pix at x=200, y=100 with rgb_rdy=1 -> next cycle x=0, y=0, frame=0, sof=1.
//  7 Run 256 frames with FRAME_W=8 -> frame wraps 255->0; gradient b wraps to 0.

Source files
------------

// File: rtl/smoldvi_pattern_gen.sv
// Test-pattern source for the smoldvi encoder (clk_pix domain).
// Walks x/y/frame under the rgb_rdy pull handshake and registers the colour of the pixel consumed next.
module smoldvi_pattern_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned X_STEP     = 2,
  parameter int unsigned FRAME_W    = 8,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic                          clk_pix,
  input  logic                          rst_pix,
  input  logic [1:0]                    mode,
  input  logic [23:0]                   solid_rgb,
  input  logic                          freeze,
  input  logic                          rgb_rdy,
  output logic [7:0]                    r,
  output logic [7:0]                    g,
  output logic [7:0]                    b,
  output logic [$clog2(H_ACTIVE)-1:0]   x,
  output logic [$clog2(V_ACTIVE)-1:0]   y,
  output logic [FRAME_W-1:0]            frame,
  output logic                          sof,
  output logic                          eol
);

  localparam int unsigned XW    = $clog2(H_ACTIVE);
  localparam int unsigned YW    = $clog2(V_ACTIVE);
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - X_STEP);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [XW-1:0] X_INC  = XW'(X_STEP);

  logic [1:0]          mode_q, mode_n;
  logic [23:0]         solid_q, solid_n;
  logic [XW-1:0]       x_n;
  logic [YW-1:0]       y_n;
  logic [FRAME_W-1:0]  frame_n;
  logic [23:0]         rgb_n, rgb_rst;

  // Colour of pixel (px,py) in frame pf for pattern m.
  function automatic logic [23:0] pattern(input logic [1:0]         m,
                                          input logic [XW-1:0]      px,
                                          input logic [YW-1:0]      py,
                                          input logic [FRAME_W-1:0] pf,
                                          input logic [23:0]        ps);
    logic [7:0] f8;
    logic [2:0] bar;
    logic       chk;
    f8  = 8'(pf);
    bar = 3'(px / XW'(BAR_W));
    chk = px[CHECK_LOG2] ^ py[CHECK_LOG2] ^ pf[0];
    case (m)
      2'd0:    pattern = {8'(px) + f8, 8'(py) + (f8 << 1), f8};
      // Bar order W,Y,C,G,M,R,B,K maps each component onto one bit of the index.
      2'd1:    pattern = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
      2'd2:    pattern = {24{chk}};
      default: pattern = ps;
    endcase
  endfunction

  // Next pixel position; mode and solid colour only change at the frame wrap.
  always_comb begin
    x_n     = x;
    y_n     = y;
    frame_n = frame;
    mode_n  = mode_q;
    solid_n = solid_q;
    if (rgb_rdy) begin
      if (x == X_LAST) begin
        x_n = '0;
        if (y == Y_LAST) begin
          y_n     = '0;
          mode_n  = mode;
          solid_n = solid_rgb;
          if (!freeze) frame_n = frame + FRAME_W'(1);
        end else begin
          y_n = y + YW'(1);
        end
      end else begin
        x_n = x + X_INC;
      end
    end
    rgb_n   = pattern(mode_n, x_n, y_n, frame_n, solid_n);
    rgb_rst = pattern(mode, '0, '0, '0, solid_rgb);
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      x         <= '0;
      y         <= '0;
      frame     <= '0;
      mode_q    <= mode;
      solid_q   <= solid_rgb;
      {r, g, b} <= rgb_rst;
      sof       <= 1'b1;
      eol       <= 1'b0;
    end else begin
      x         <= x_n;
      y         <= y_n;
      frame     <= frame_n;
      mode_q    <= mode_n;
      solid_q   <= solid_n;
      {r, g, b} <= rgb_n;
      sof       <= (x_n == '0) && (y_n == '0);
      eol       <= (x_n == X_LAST);
    end
  end

endmodule
